// File: rtl/wshb_pkg.sv
// Shared definitions for the Wishbone arbiter slice.
// Provides the arbiter state encoding and default bus widths.
package wshb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_t;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/wshb_arbiter.sv
// Two-master / one-slave pipelined Wishbone arbiter.
// Master 0 is the VGA frame-buffer reader, master 1 the test-pattern writer;
// both share the SDRAM controller port. A grant lasts for the whole bus
// cycle and is never preempted. Outstanding transfers are tracked and
// protocol violations raise a sticky flag.
//
// Build option: define WSHB_ARB_RR_EN for round-robin arbitration on a
// simultaneous request from IDLE; otherwise master 0 has fixed priority.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   m{0,1}_cyc/stb/we     master request
//   m{0,1}_adr/dat_w/sel  master address, write data, byte select
//   m{0,1}_ack/stall      master response (routed from the slave)
//   m{0,1}_dat_r          read data (broadcast from the slave)
//   s_*                   slave-side bus
//   grant                 one-hot current owner, 00 when idle
//   proto_err             sticky protocol-violation flag
//
// state | meaning
// IDLE  | no owner, slave sees cyc = stb = 0
// G0    | master 0 owns the bus
// G1    | master 1 owns the bus
module wshb_arbiter
  import wshb_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int OUT_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_w,
  input  logic [DW/8-1:0] m0_sel,
  output logic            m0_ack,
  output logic            m0_stall,
  output logic [DW-1:0]   m0_dat_r,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_w,
  input  logic [DW/8-1:0] m1_sel,
  output logic            m1_ack,
  output logic            m1_stall,
  output logic [DW-1:0]   m1_dat_r,
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_w,
  output logic [DW/8-1:0] s_sel,
  input  logic            s_ack,
  input  logic            s_stall,
  input  logic [DW-1:0]   s_dat_r,
  output logic [1:0]      grant,
  output logic            proto_err
);

  arb_state_t       state_q, state_d;
  logic             last_q, last_d;
  logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
  logic             proto_err_q, proto_err_d;

  logic inc, dec, owner_drop;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    out_cnt_d   = out_cnt_q;
    proto_err_d = proto_err_q;

    case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
`ifdef WSHB_ARB_RR_EN
          state_d = last_q ? G0 : G1;
`else
          state_d = G0;
`endif
        end else if (m0_cyc) begin
          state_d = G0;
        end else if (m1_cyc) begin
          state_d = G1;
        end
      end
      G0:      if (!m0_cyc) state_d = m1_cyc ? G1 : IDLE;
      G1:      if (!m1_cyc) state_d = m0_cyc ? G0 : IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == G0 && state_q != G0) last_d = 1'b0;
    if (state_d == G1 && state_q != G1) last_d = 1'b1;

    inc        = s_stb & ~s_stall;
    dec        = s_ack;
    owner_drop = (state_q == G0 && !m0_cyc) || (state_q == G1 && !m1_cyc);

    // A new owner starts with a clean count; stale acks belong to the old one.
    if (state_d != state_q) begin
      out_cnt_d = '0;
    end else if (inc && !dec) begin
      out_cnt_d = out_cnt_q + OUT_W'(1);
    end else if (dec && !inc && out_cnt_q != '0) begin
      out_cnt_d = out_cnt_q - OUT_W'(1);
    end

    if (s_ack && out_cnt_q == '0)          proto_err_d = 1'b1;
    if (inc && !dec && (&out_cnt_q))       proto_err_d = 1'b1;
    if (owner_drop && out_cnt_q != '0)     proto_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      out_cnt_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      out_cnt_q   <= out_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Routing is purely combinational from the registered state so acks and
  // data pass through with no added latency.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_w  = '0;
    s_sel    = '0;
    m0_ack   = 1'b0;
    m0_stall = 1'b1;
    m1_ack   = 1'b0;
    m1_stall = 1'b1;
    case (state_q)
      G0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_w  = m0_dat_w;
        s_sel    = m0_sel;
        m0_ack   = s_ack;
        m0_stall = s_stall;
      end
      G1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_w  = m1_dat_w;
        s_sel    = m1_sel;
        m1_ack   = s_ack;
        m1_stall = s_stall;
      end
      default: ;
    endcase
  end

  assign m0_dat_r  = s_dat_r;
  assign m1_dat_r  = s_dat_r;
  assign grant     = {state_q == G1, state_q == G0};
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed self-checking bench for wshb_arbiter. Expected grants in the
// alternation test depend on whether WSHB_ARB_RR_EN is defined.
module tb_wshb_arbiter;
  import wshb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef WSHB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            m0_cyc, m0_stb, m0_we, m0_ack, m0_stall;
  logic [AW-1:0]   m0_adr;
  logic [DW-1:0]   m0_dat_w, m0_dat_r;
  logic [DW/8-1:0] m0_sel;
  logic            m1_cyc, m1_stb, m1_we, m1_ack, m1_stall;
  logic [AW-1:0]   m1_adr;
  logic [DW-1:0]   m1_dat_w, m1_dat_r;
  logic [DW/8-1:0] m1_sel;
  logic            s_cyc, s_stb, s_we, s_ack, s_stall;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_w, s_dat_r;
  logic [DW/8-1:0] s_sel;
  logic [1:0]      grant;
  logic            proto_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  wshb_arbiter #(.AW(AW), .DW(DW), .OUT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_stall(m0_stall),
    .m0_dat_r(m0_dat_r),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_stall(m1_stall),
    .m1_dat_r(m1_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_sel(s_sel), .s_ack(s_ack), .s_stall(s_stall), .s_dat_r(s_dat_r),
    .grant(grant), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_w = '0; m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_w = '0; m1_sel = '0;
    s_ack = 0; s_stall = 0; s_dat_r = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    chk_cnt++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant); else pass_cnt++;
    chk_cnt++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) $display("FAIL rst_s_cyc_stb: got %b%b want 00", s_cyc, s_stb); else pass_cnt++;
    chk_cnt++; if (m0_stall !== 1'b1 || m1_stall !== 1'b1) $display("FAIL rst_stall: got %b%b want 11", m0_stall, m1_stall); else pass_cnt++;
    chk_cnt++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) $display("FAIL rst_ack: got %b%b want 00", m0_ack, m1_ack); else pass_cnt++;
    chk_cnt++; if (proto_err !== 1'b0) $display("FAIL rst_proto_err: got %b want 0", proto_err); else pass_cnt++;
    chk_cnt++; if (dut.out_cnt_q !== 4'd0) $display("FAIL rst_out_cnt: got %0d want 0", dut.out_cnt_q); else pass_cnt++;
    chk_cnt++; if (dut.last_q !== 1'b1) $display("FAIL rst_last: got %b want 1", dut.last_q); else pass_cnt++;
  endtask

  task automatic test_m0_reads();
    int  acks = 0;
    int  accepted = 0;
    bit  pending = 0;
    bit  acc;
    bit  bad_stall = 0;
    bit  bad_dat = 0;
    do_reset();
    m0_adr = 32'h0000_1000; m0_sel = 4'hF; m0_cyc = 1; m0_stb = 1; m0_we = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      s_ack   = pending;
      s_dat_r = 32'hA5A5_0000 + i;
      m0_stb  = (accepted < 8);
      #1;
      if (i == 0) begin
        chk_cnt++; if (grant !== 2'b01) $display("FAIL m0_grant_latency: got %b want 01", grant); else pass_cnt++;
        chk_cnt++; if (s_stb !== 1'b1 || s_adr !== 32'h0000_1000) $display("FAIL m0_first_stb: got stb=%b adr=%h want 1/00001000", s_stb, s_adr); else pass_cnt++;
      end
      if (m1_stall !== 1'b1) bad_stall = 1;
      if (m0_dat_r !== s_dat_r || m1_dat_r !== s_dat_r) bad_dat = 1;
      if (m0_ack === 1'b1) acks++;
      acc      = s_stb & ~s_stall;
      accepted += int'(acc);
      pending  = acc;
      if (acks == 8) break;
    end
    chk_cnt++; if (acks != 8) $display("FAIL m0_ack_count: got %0d want 8", acks); else pass_cnt++;
    chk_cnt++; if (bad_stall) $display("FAIL m0_m1_stall: got 0 at least once want 1"); else pass_cnt++;
    chk_cnt++; if (bad_dat) $display("FAIL m0_dat_r_broadcast: got mismatch want s_dat_r"); else pass_cnt++;
    step();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    step();
    chk_cnt++; if (grant !== 2'b00) $display("FAIL m0_release: got %b want 00", grant); else pass_cnt++;
    chk_cnt++; if (proto_err !== 1'b0) $display("FAIL m0_proto_err: got %b want 0", proto_err); else pass_cnt++;
  endtask

  task automatic test_handover();
    do_reset();
    m0_cyc = 1; m1_cyc = 1;
    step();
    chk_cnt++; if (grant !== 2'b01) $display("FAIL ho_first: got %b want 01", grant); else pass_cnt++;
    m0_cyc = 0;
    step();
    chk_cnt++; if (grant !== 2'b10) $display("FAIL ho_grant: got %b want 10", grant); else pass_cnt++;
    chk_cnt++; if (s_cyc !== 1'b1) $display("FAIL ho_s_cyc: got %b want 1", s_cyc); else pass_cnt++;
    chk_cnt++; if (m1_stall !== 1'b0 || m0_stall !== 1'b1) $display("FAIL ho_stall: got m0=%b m1=%b want 1/0", m0_stall, m1_stall); else pass_cnt++;
    m1_cyc = 0;
    step();
    chk_cnt++; if (grant !== 2'b00) $display("FAIL ho_idle: got %b want 00", grant); else pass_cnt++;
  endtask

  task automatic test_alternate();
    logic [1:0] exp;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      m0_cyc = 1; m1_cyc = 1;
      step();
      exp = (RR && (r % 2 == 1)) ? 2'b10 : 2'b01;
      chk_cnt++; if (grant !== exp) $display("FAIL alt_round%0d: got %b want %b", r, grant, exp); else pass_cnt++;
      m0_cyc = 0; m1_cyc = 0;
      step();
      chk_cnt++; if (grant !== 2'b00) $display("FAIL alt_idle%0d: got %b want 00", r, grant); else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    bit bad_stall = 0;
    bit bad_cnt   = 0;
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_2040;
    m1_dat_w = 32'hDEAD_BEEF; m1_sel = 4'hC;
    step();
    chk_cnt++; if (grant !== 2'b10 || s_we !== 1'b1) $display("FAIL st_grant: got grant=%b we=%b want 10/1", grant, s_we); else pass_cnt++;
    chk_cnt++; if (s_adr !== 32'h0000_2040 || s_dat_w !== 32'hDEAD_BEEF || s_sel !== 4'hC) $display("FAIL st_route: got %h %h %h want 00002040 deadbeef c", s_adr, s_dat_w, s_sel); else pass_cnt++;
    step();
    s_stall = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (m1_stall !== 1'b1) bad_stall = 1;
      step();
      if (dut.out_cnt_q !== 4'd1) bad_cnt = 1;
    end
    chk_cnt++; if (bad_stall) $display("FAIL st_m1_stall: got 0 want 1"); else pass_cnt++;
    chk_cnt++; if (bad_cnt) $display("FAIL st_out_cnt_hold: got %0d want 1", dut.out_cnt_q); else pass_cnt++;
    s_stall = 0;
    step();
    chk_cnt++; if (dut.out_cnt_q !== 4'd2) $display("FAIL st_out_cnt_resume: got %0d want 2", dut.out_cnt_q); else pass_cnt++;
    m1_stb = 0; s_ack = 1;
    step();
    chk_cnt++; if (dut.out_cnt_q !== 4'd1) $display("FAIL st_ack1: got %0d want 1", dut.out_cnt_q); else pass_cnt++;
    step();
    chk_cnt++; if (dut.out_cnt_q !== 4'd0) $display("FAIL st_ack2: got %0d want 0", dut.out_cnt_q); else pass_cnt++;
    s_ack = 0; m1_cyc = 0;
    step();
    chk_cnt++; if (grant !== 2'b00 || proto_err !== 1'b0) $display("FAIL st_end: got grant=%b err=%b want 00/0", grant, proto_err); else pass_cnt++;
  endtask

  task automatic test_spurious_ack();
    do_reset();
    s_ack = 1;
    step();
    s_ack = 0;
    chk_cnt++; if (proto_err !== 1'b1) $display("FAIL sp_set: got %b want 1", proto_err); else pass_cnt++;
    step(); step(); step();
    chk_cnt++; if (proto_err !== 1'b1) $display("FAIL sp_sticky: got %b want 1", proto_err); else pass_cnt++;
    do_reset();
    chk_cnt++; if (proto_err !== 1'b0) $display("FAIL sp_clear: got %b want 0", proto_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    step();
    step();
    step();
    chk_cnt++; if (dut.out_cnt_q !== 4'd2) $display("FAIL rm_outstanding: got %0d want 2", dut.out_cnt_q); else pass_cnt++;
    rst_n = 0; s_ack = 1;
    step();
    chk_cnt++; if (grant !== 2'b00 || s_cyc !== 1'b0) $display("FAIL rm_idle: got grant=%b s_cyc=%b want 00/0", grant, s_cyc); else pass_cnt++;
    chk_cnt++; if (dut.out_cnt_q !== 4'd0) $display("FAIL rm_out_cnt: got %0d want 0", dut.out_cnt_q); else pass_cnt++;
    chk_cnt++; if (proto_err !== 1'b0) $display("FAIL rm_proto_err: got %b want 0", proto_err); else pass_cnt++;
    rst_n = 1; s_ack = 0; m0_cyc = 0; m0_stb = 0;
    step();
  endtask

  task automatic test_overflow();
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    step();
    for (int k = 0; k < 15; k++) step();
    chk_cnt++; if (dut.out_cnt_q !== 4'd15 || proto_err !== 1'b0) $display("FAIL ov_full: got cnt=%0d err=%b want 15/0", dut.out_cnt_q, proto_err); else pass_cnt++;
    step();
    chk_cnt++; if (proto_err !== 1'b1) $display("FAIL ov_flag: got %b want 1", proto_err); else pass_cnt++;
    m0_cyc = 0; m0_stb = 0;
  endtask

  task automatic test_drop_err();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1;
    step();
    step();
    m0_cyc = 0; m0_stb = 0;
    step();
    chk_cnt++; if (proto_err !== 1'b1) $display("FAIL drop_flag: got %b want 1", proto_err); else pass_cnt++;
    chk_cnt++; if (grant !== 2'b10) $display("FAIL drop_switch: got %b want 10", grant); else pass_cnt++;
    m1_cyc = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_m0_reads();
    test_handover();
    test_alternate();
    test_stall();
    test_spurious_ack();
    test_reset_mid();
    test_overflow();
    test_drop_err();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
